alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the datapath execute stage. Replaces the
//  fixed 32-bit combinational ALU: width is a parameter, results and status
//  flags are registered, a valid/ready handshake is used, and SRL and an
//  iterative MUL (low half) are added. Signed SLT is corrected for overflow.
// PARAMETERS
//  WIDTH   32  data width in bits (>=4, power of 2)
//  SHW     5   shift-amount bits, must equal log2(WIDTH)
// PORTS
//  clk       in   1      system clock, all state on rising edge
//  rst_n     in   1      synchronous active-low reset
//  in_valid  in   1      operands and op valid
//  in_ready  out  1      ALU can accept an op this cycle
//  a         in   WIDTH  operand A
//  b         in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  gin       in   3      ALU control line (op code)
//  stswrite  in   1      update status with this op (sampled with op)
//  out_valid out  1      sum valid
//  out_ready in   1      consumer takes sum
//  sum       out  WIDTH  registered result
//  status    out  3      {zero, negative, overflow}, registered
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): sum=0, status=3'b000, out_valid=0,
//   in_ready=1, FSM->IDLE; an in-flight op is discarded, no output produced.
//  Op codes: 010 ADD a+b; 110 SUB a-b; 111 SLT signed (sum=1 if a<b else 0,
//   via diff[W-1]^ovf); 000 AND; 001 OR; 101 SLL a<<b[SHW-1:0];
//   011 SRL logical a>>b[SHW-1:0]; 100 MUL low WIDTH bits of a*b.
//  Accept: in_valid & in_ready at edge; a, b, gin, stswrite latched.
//  FSM: IDLE, MUL, DONE.
//   IDLE: accept non-MUL -> compute, load sum, -> DONE (latency 1 clock).
//         accept MUL -> load multiplicand/multiplier, count=0, -> MUL.
//   MUL:  shift-add one bit per clock, WIDTH clocks; on last -> load sum,
//         -> DONE. Latency MUL = WIDTH+1 clocks from accept to out_valid.
//   DONE: out_valid=1; sum stable until out_valid & out_ready.
//         On handshake: if in_valid same cycle, accept next op (back-to-back)
//         else -> IDLE.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Low during MUL.
//  out_valid=1 only in DONE; sum/status never change while out_valid & ~out_ready.
//  Status: written on the clock sum is loaded, only if latched stswrite=1;
//   else previous status held indefinitely.
//   zero = ~|sum; negative = sum[W-1];
//   overflow: ADD (a,b same sign, sum differs); SUB/SLT (a,~b same sign,
//   difference differs); all other ops 0.
//  Arithmetic modulo 2^WIDTH; carry-out discarded; shift amount >= WIDTH
//   impossible (only SHW bits used). MUL signed/unsigned low half identical.
// TESTING (WIDTH=32)
//  ADD a=7,b=5,stswrite=1 -> next clk out_valid=1, sum=12, status=000.
//  SUB a=5,b=5 then ADD 0x7FFFFFFF+1 back-to-back, out_ready=1 -> sums
//   0 (status 100) then 0x80000000 (status 011) on consecutive clocks.
//  SLT a=0x80000000,b=1 -> sum=1; SRL a=0x80000000,b=31 -> sum=1.
//  MUL a=3,b=0xFFFFFFFE -> out_valid 33 clks after accept, sum=0xFFFFFFFA,
//   in_ready=0 throughout MUL.
//  out_ready=0 for 5 clks in DONE -> sum/status/out_valid held; stswrite=0 op
//   -> status unchanged from previous op.
//  rst_n=0 at MUL cycle 10 -> next clk out_valid=0, in_ready=1, sum=0,
//   status=000; no stale result emitted afterwards.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU for the execute stage.
// Single-cycle ops finish one clock after acceptance; MUL runs an iterative
// shift-add over WIDTH clocks. Result and status flags are registered and
// handed to the consumer through a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       gin,
  input  logic             stswrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [2:0]       status
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // The counter runs one past the last step so the final load gets its own clock.
  localparam logic [SHW:0] CntDone = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CntOne  = (SHW+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sum;
  logic [2:0]       r_status;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW:0]     r_cnt;
  logic             r_stsw;

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_diff;
  logic             w_addOvf;
  logic             w_subOvf;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_accept;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign status    = r_status;
  assign w_accept  = in_valid & in_ready;

  assign w_add    = a + b;
  assign w_diff   = a - b;
  assign w_addOvf = (a[WIDTH-1] == b[WIDTH-1]) & (w_add[WIDTH-1] != a[WIDTH-1]);
  assign w_subOvf = (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);

  // Single-cycle result and overflow flag for every op except MUL.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (gin)
      OP_ADD: begin
        w_res = w_add;
        w_ovf = w_addOvf;
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = w_subOvf;
      end
      OP_SLT: begin
        w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_subOvf};
        w_ovf = w_subOvf;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_SLL: w_res = a << b[SHW-1:0];
      OP_SRL: w_res = a >> b[SHW-1:0];
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // Control FSM plus result/status registers and the shift-add multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sum    <= '0;
      r_status <= 3'b000;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_stsw   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (gin == OP_MUL) begin
              r_mcand  <= a;
              r_mplier <= b;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_stsw   <= stswrite;
              r_state  <= MUL;
            end else begin
              r_sum <= w_res;
              if (stswrite) begin
                r_status <= {~|w_res, w_res[WIDTH-1], w_ovf};
              end
              r_state <= DONE;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state <= IDLE;
          end
        end
        MUL: begin
          if (r_cnt == CntDone) begin
            r_sum <= r_acc;
            if (r_stsw) begin
              r_status <= {~|r_acc, r_acc[WIDTH-1], 1'b0};
            end
            r_state <= DONE;
          end else begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CntOne;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc at WIDTH=32.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  gin;
  logic        stswrite;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic [2:0]  status;

  int checkCount;
  int failCount;
  int cycles;
  int badCount;

  alu_mc #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .gin       (gin),
    .stswrite  (stswrite),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .status    (status)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op and returns 1 unit after the edge that accepted it.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb, input logic sw);
    logic wasReady;
    int   n;
    gin      = op;
    a        = va;
    b        = vb;
    stswrite = sw;
    in_valid = 1'b1;
    n        = 0;
    wasReady = 1'b0;
    while (!wasReady && n < 100) begin
      wasReady = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!wasReady) checkOutput("accept_timeout", 64'(n), 64'(0));
  endtask

  // Lets the consumer take the current result.
  task automatic drainOutput();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    a          = '0;
    b          = '0;
    gin        = 3'b000;
    stswrite   = 1'b0;
    tick();
    tick();
    checkOutput("rst_sum", 64'(sum), 64'(0));
    checkOutput("rst_status", 64'(status), 64'(0));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    tick();

    // ADD with one-clock latency
    applyStimulus(3'b010, 32'd7, 32'd5, 1'b1);
    checkOutput("add_valid", 64'(out_valid), 64'(1));
    checkOutput("add_sum", 64'(sum), 64'(12));
    checkOutput("add_status", 64'(status), 64'(3'b000));
    drainOutput();
    checkOutput("add_idle", 64'(out_valid), 64'(0));

    // Back-to-back SUB then overflowing ADD
    applyStimulus(3'b110, 32'd5, 32'd5, 1'b1);
    gin       = 3'b010;
    a         = 32'h7FFF_FFFF;
    b         = 32'h0000_0001;
    stswrite  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    checkOutput("sub_valid", 64'(out_valid), 64'(1));
    checkOutput("sub_sum", 64'(sum), 64'(0));
    checkOutput("sub_status", 64'(status), 64'(3'b100));
    tick();
    in_valid = 1'b0;
    checkOutput("b2b_valid", 64'(out_valid), 64'(1));
    checkOutput("b2b_sum", 64'(sum), 64'h8000_0000);
    checkOutput("b2b_status", 64'(status), 64'(3'b011));
    tick();
    out_ready = 1'b0;
    checkOutput("b2b_idle", 64'(out_valid), 64'(0));

    // Signed SLT with overflowing difference
    applyStimulus(3'b111, 32'h8000_0000, 32'd1, 1'b1);
    checkOutput("slt_sum", 64'(sum), 64'(1));
    checkOutput("slt_status", 64'(status), 64'(3'b001));
    drainOutput();

    // Logical right shift by WIDTH-1
    applyStimulus(3'b011, 32'h8000_0000, 32'd31, 1'b1);
    checkOutput("srl_sum", 64'(sum), 64'(1));
    checkOutput("srl_status", 64'(status), 64'(3'b000));
    drainOutput();

    // Iterative MUL: latency and in_ready held low
    applyStimulus(3'b100, 32'd3, 32'hFFFF_FFFE, 1'b1);
    cycles   = 0;
    badCount = 0;
    while (!out_valid && cycles < 60) begin
      if (in_ready) badCount++;
      tick();
      cycles++;
    end
    checkOutput("mul_latency", 64'(cycles), 64'(33));
    checkOutput("mul_in_ready_low", 64'(badCount), 64'(0));
    checkOutput("mul_sum", 64'(sum), 64'hFFFF_FFFA);
    checkOutput("mul_status", 64'(status), 64'(3'b010));

    // Result held while the consumer stalls
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("hold_valid", 64'(out_valid), 64'(1));
      checkOutput("hold_sum", 64'(sum), 64'hFFFF_FFFA);
      checkOutput("hold_status", 64'(status), 64'(3'b010));
    end
    drainOutput();

    // stswrite=0 keeps the previous status
    applyStimulus(3'b000, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    checkOutput("and_sum", 64'(sum), 64'(0));
    checkOutput("and_status_held", 64'(status), 64'(3'b010));
    drainOutput();
    applyStimulus(3'b001, 32'h0000_00F0, 32'h0000_000F, 1'b1);
    checkOutput("or_sum", 64'(sum), 64'h0000_00FF);
    checkOutput("or_status", 64'(status), 64'(3'b000));
    drainOutput();
    applyStimulus(3'b101, 32'd1, 32'd31, 1'b1);
    checkOutput("sll_sum", 64'(sum), 64'h8000_0000);
    checkOutput("sll_status", 64'(status), 64'(3'b010));
    drainOutput();

    // Reset in the middle of a MUL discards it
    applyStimulus(3'b100, 32'd3, 32'd5, 1'b1);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("mrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("mrst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("mrst_sum", 64'(sum), 64'(0));
    checkOutput("mrst_status", 64'(status), 64'(0));
    rst_n    = 1'b1;
    badCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) badCount++;
    end
    checkOutput("mrst_no_stale", 64'(badCount), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
